decomp_sched: RTL

Request scheduler that shares one line decompressor among several requesters. It accepts compressed 256-bit lines with their 4-bit encoding from NUM_REQ clients and picks one at a time by round-robin. It drives the decompressor's enable/data/encoding inputs and captures the decompressed line. The result goes back through a single response channel tagged with the requester id, sitting between the line-fill clients and the decompressor datapath.

---
 rtl/decomp_pkg.sv | 24 ++
 rtl/decomp_rr_arbiter.sv | 31 +++
 rtl/decomp_sched.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/decomp_pkg.sv
// decomp_pkg: shared line/encoding widths, encoding constants and the
// scheduler FSM state type used by decomp_sched and its arbiter.
package decomp_pkg;

  localparam int LINE_W = 256;
  localparam int ENC_W  = 4;

  // Encoding values are carried through the scheduler untouched.
  localparam logic [ENC_W-1:0] ENC_ZERO = 4'd0;
  localparam logic [ENC_W-1:0] ENC_B8D1 = 4'd2;
  localparam logic [ENC_W-1:0] ENC_B8D4 = 4'd3;
  localparam logic [ENC_W-1:0] ENC_B8D2 = 4'd4;
  localparam logic [ENC_W-1:0] ENC_B4D2 = 4'd5;
  localparam logic [ENC_W-1:0] ENC_B4D1 = 4'd6;
  localparam logic [ENC_W-1:0] ENC_B2D1 = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/decomp_rr_arbiter.sv
// decomp_rr_arbiter: combinational round-robin picker. Searches req starting
// at ptr and wrapping through index 0; returns a one-hot grant and its index.
// The pointer register lives in the parent.
module decomp_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // First requester at or after ptr (modulo NUM_REQ) wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned      c;
      logic [IDX_W-1:0] c_idx;
      c = 32'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      c_idx = IDX_W'(c);
      if ((grant == '0) && req[c_idx]) begin
        grant[c_idx] = 1'b1;
        idx          = c_idx;
      end
    end
  end

endmodule

// File: rtl/decomp_sched.sv
// decomp_sched: shares one line decompressor among NUM_REQ requesters.
// Round-robin accept, one-cycle dec_enable pulse, wait for dec_ready, return
// the line tagged with requester id. One request in flight at a time.
// Optional feature: define DECOMP_SCHED_WATCHDOG_EN to bound the WAIT state
// at TIMEOUT cycles (raw line returned with rsp_err=1 on expiry).
module decomp_sched
  import decomp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*LINE_W-1:0]  req_data,
  input  logic [NUM_REQ*ENC_W-1:0]   req_encoding,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic                       dec_enable,
  output logic [LINE_W-1:0]          dec_i_data,
  output logic [ENC_W-1:0]           dec_encoding,
  input  logic                       dec_ready,
  input  logic [LINE_W-1:0]          dec_o_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [LINE_W-1:0]          rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
    $error("decomp_sched: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  sched_state_e       state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   hold_id_q;
  logic [NUM_REQ-1:0] grant;
  logic [LINE_W-1:0]  hold_data_q;
  logic [LINE_W-1:0]  sel_data;
  logic [ENC_W-1:0]   hold_enc_q;
  logic [ENC_W-1:0]   sel_enc;
  logic [TAG_W-1:0]   hold_tag_q;
  logic [TAG_W-1:0]   sel_tag;
  logic               take;

`ifdef DECOMP_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]    wd_cnt_q;
`else
  assign rsp_err = 1'b0;
`endif

  decomp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (win_idx)
  );

  // Offer the arbiter's pick only while idle; grant is already one-hot.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE) req_ready = grant;
  end

  assign take = (state_q == ST_IDLE) && (grant != '0);

  // One-hot select of the winning requester's payload.
  always_comb begin
    sel_data = '0;
    sel_enc  = '0;
    sel_tag  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_data = req_data[LINE_W*k +: LINE_W];
        sel_enc  = req_encoding[ENC_W*k +: ENC_W];
        sel_tag  = req_tag[TAG_W*k +: TAG_W];
      end
    end
  end

  assign dec_i_data   = hold_data_q;
  assign dec_encoding = hold_enc_q;
  assign rsp_id       = hold_id_q;
  assign rsp_tag      = hold_tag_q;

  // Scheduler FSM: accept, pulse the decompressor, wait for its result, respond.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      hold_data_q <= '0;
      hold_enc_q  <= '0;
      hold_tag_q  <= '0;
      hold_id_q   <= '0;
      dec_enable  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      busy        <= 1'b0;
`ifdef DECOMP_SCHED_WATCHDOG_EN
      rsp_err     <= 1'b0;
      wd_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            hold_data_q <= sel_data;
            hold_enc_q  <= sel_enc;
            hold_tag_q  <= sel_tag;
            hold_id_q   <= win_idx;
            rr_ptr_q    <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            dec_enable  <= 1'b1;
            busy        <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          dec_enable <= 1'b0;
          state_q    <= ST_WAIT;
`ifdef DECOMP_SCHED_WATCHDOG_EN
          wd_cnt_q   <= '0;
`endif
        end
        ST_WAIT: begin
          if (dec_ready) begin
            rsp_data  <= dec_o_data;
            rsp_valid <= 1'b1;
            state_q   <= ST_RESP;
`ifdef DECOMP_SCHED_WATCHDOG_EN
            rsp_err   <= 1'b0;
`endif
          end
`ifdef DECOMP_SCHED_WATCHDOG_EN
          // wd_cnt_q holds the number of WAIT cycles already spent.
          else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
            rsp_data  <= hold_data_q;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_q   <= ST_RESP;
          end else begin
            wd_cnt_q  <= wd_cnt_q + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
